// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
// Holds the sequencer state enum, lcd_ctrl bit positions and default panel timings.
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  localparam int unsigned LcdRsBit = 0;
  localparam int unsigned LcdRwBit = 1;

  localparam int unsigned DefSetupCyc     = 2;
  localparam int unsigned DefPulseCyc     = 12;
  localparam int unsigned DefHoldCyc      = 2;
  localparam int unsigned DefShortWaitCyc = 2000;
  localparam int unsigned DefLongWaitCyc  = 82000;
  localparam int unsigned DefFifoDepth    = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd_byte);
    return !rs && (cmd_byte[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// Command-side handshake bundle: a producer pushes {rs, byte} when cmd_ready is high.
interface lcd_controller_if;

  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_byte;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_byte,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_byte,
    output cmd_ready
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Power-of-two command queue with level/full/empty; pushes while full and pops while
// empty are ignored, and pointers wrap naturally at Depth.
module lcd_cmd_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once the level says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lcd_controller.sv
// Queued write sequencer for a parallel character LCD: drives RS/data, the E strobe
// with setup/pulse/hold timing, then waits out the panel's execution time.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DefSetupCyc,
  parameter int unsigned PULSE_CYC      = DefPulseCyc,
  parameter int unsigned HOLD_CYC       = DefHoldCyc,
  parameter int unsigned SHORT_WAIT_CYC = DefShortWaitCyc,
  parameter int unsigned LONG_WAIT_CYC  = DefLongWaitCyc,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_controller_if.slave             cmd,
  output logic [7:0]                  lcd_data,
  output logic [1:0]                  lcd_ctrl,
  output logic                        lcd_enable,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned MaxCyc = max_u(max_u(SETUP_CYC, PULSE_CYC),
                                         max_u(max_u(HOLD_CYC, SHORT_WAIT_CYC), LONG_WAIT_CYC));
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  lcd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic            long_q, long_d;
  logic            take;
  logic [8:0]      fifo_rdata;
  logic            fifo_full, fifo_empty;

  lcd_cmd_fifo #(
    .Width (9),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd.cmd_valid),
    .wdata_i ({cmd.cmd_rs, cmd.cmd_byte}),
    .pop_i   (take),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd.cmd_ready      = !fifo_full;
  assign lcd_data           = data_q;
  assign lcd_enable         = en_q;
  assign lcd_ctrl[LcdRsBit] = rs_q;
  assign lcd_ctrl[LcdRwBit] = 1'b0;
  assign busy               = (state_q != StIdle) || (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    long_d  = long_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: take = !fifo_empty;
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          en_d    = 1'b1;
          cnt_d   = CntW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          en_d    = 1'b0;
          cnt_d   = CntW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = long_q ? CntW'(LONG_WAIT_CYC - 1) : CntW'(SHORT_WAIT_CYC - 1);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          // Chain straight into a queued entry so back-to-back writes have no idle bubble.
          take    = !fifo_empty;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      state_d = StSetup;
      data_d  = fifo_rdata[7:0];
      rs_d    = fifo_rdata[8];
      long_d  = is_long_cmd(fifo_rdata[8], fifo_rdata[7:0]);
      cnt_d   = CntW'(SETUP_CYC - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      long_q  <= long_d;
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with short timings (2/3/1, waits 4/10, depth 4).
// A panel-side monitor captures {rs, data} on every falling edge of E.
module tb_lcd_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic       busy;
  logic [2:0] fifo_level;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [8:0]  cap_q [$];
  logic [8:0]  ovf_exp [5];

  lcd_controller_if cmd_if ();

  lcd_controller #(
    .SETUP_CYC      (2),
    .PULSE_CYC      (3),
    .HOLD_CYC       (1),
    .SHORT_WAIT_CYC (4),
    .LONG_WAIT_CYC  (10),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .lcd_data   (lcd_data),
    .lcd_ctrl   (lcd_ctrl),
    .lcd_enable (lcd_enable),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge lcd_enable) begin
    if (rst_n) cap_q.push_back({lcd_ctrl[0], lcd_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rs    = 1'b0;
    cmd_if.cmd_byte  = 8'h00;
    #12;
    n_cmp++; if (lcd_enable !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", lcd_enable); end
    n_cmp++; if ({lcd_ctrl, lcd_data} !== 10'h000) begin n_bad++; $display("FAIL reset_bus: got %h want 000", {lcd_ctrl, lcd_data}); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset: got busy=%b ready=%b want busy=0 ready=1", busy, cmd_if.cmd_ready);
    end
  endtask

  task automatic test_single_write();
    cap_q.delete();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rs    = 1'b1;
    cmd_if.cmd_byte  = 8'h41;
    tick();  // edge T
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_queued: got level=%0d busy=%b want level=1 busy=1", fifo_level, busy);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_cmp++; if (lcd_enable !== (k >= 3 && k <= 5)) begin
        n_bad++; $display("FAIL single_en T+%0d: got %b want %b", k, lcd_enable, (k >= 3 && k <= 5));
      end
      n_cmp++; if ({lcd_ctrl, lcd_data} !== 10'h141) begin
        n_bad++; $display("FAIL single_bus T+%0d: got %h want 141", k, {lcd_ctrl, lcd_data});
      end
      n_cmp++; if (busy !== (k != 11)) begin
        n_bad++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy, (k != 11));
      end
    end
    n_cmp++; if (cap_q.size() != 1 || cap_q[0] !== 9'h141) begin
      n_bad++; $display("FAIL single_capture: got %0d entries want 1 entry 141", cap_q.size());
    end
  endtask

  task automatic test_wait_times();
    logic [8:0] vcmd [6];
    int         vexp [6];
    int         n;
    vcmd[0] = 9'h001; vexp[0] = 16;  // clear
    vcmd[1] = 9'h002; vexp[1] = 16;  // home
    vcmd[2] = 9'h003; vexp[2] = 16;
    vcmd[3] = 9'h004; vexp[3] = 10;
    vcmd[4] = 9'h038; vexp[4] = 10;
    vcmd[5] = 9'h101; vexp[5] = 10;  // data byte 0x01 is not a clear
    for (int i = 0; i < 6; i++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_rs    = vcmd[i][8];
      cmd_if.cmd_byte  = vcmd[i][7:0];
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      n_cmp++; if ({lcd_ctrl[0], lcd_data} !== vcmd[i]) begin
        n_bad++; $display("FAIL wait_bus %h: got %h want %h", vcmd[i], {lcd_ctrl[0], lcd_data}, vcmd[i]);
      end
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      n_cmp++; if (n != vexp[i]) begin
        n_bad++; $display("FAIL wait_time %h: got %0d cycles want %0d", vcmd[i], n, vexp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    cap_q.delete();
    for (int i = 0; i < 6; i++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_rs    = i[0];
      cmd_if.cmd_byte  = 8'h10 + 8'(i);
      if (i < 5) ovf_exp[i] = {i[0], 8'h10 + 8'(i)};
      n_cmp++; if (cmd_if.cmd_ready !== (i < 5)) begin
        n_bad++; $display("FAIL ovf_ready push%0d: got %b want %b", i, cmd_if.cmd_ready, (i < 5));
      end
      tick();
    end
    n_cmp++; if (fifo_level !== 3'd4 || cmd_if.cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL ovf_full: got level=%0d ready=%b want level=4 ready=0", fifo_level, cmd_if.cmd_ready);
    end
  endtask

  task automatic test_push_at_pop();
    int n = 0;
    // Keep a request pending across the pop: it must be refused because the queue is full.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rs    = 1'b1;
    cmd_if.cmd_byte  = 8'hEE;
    while (fifo_level == 3'd4 && n < 100) begin tick(); n++; end
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd3 || cmd_if.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL pushpop_level: got level=%0d ready=%b want level=3 ready=1", fifo_level, cmd_if.cmd_ready);
    end
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got busy=%b want 0", busy); end
    n_cmp++; if (cap_q.size() != 5) begin
      n_bad++; $display("FAIL ovf_count: got %0d bytes want 5", cap_q.size());
    end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_cmp++; if (cap_q[i] !== ovf_exp[i]) begin
        n_bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, cap_q[i], ovf_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_rs    = 1'b1;
      cmd_if.cmd_byte  = 8'h55 + 8'(i);
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    while (!lcd_enable && n < 50) begin tick(); n++; end
    n_cmp++; if (lcd_enable !== 1'b1 || fifo_level !== 3'd2) begin
      n_bad++; $display("FAIL mid_setup: got en=%b level=%0d want en=1 level=2", lcd_enable, fifo_level);
    end
    cap_q.delete();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (lcd_enable !== 1'b0 || lcd_data !== 8'h00 || lcd_ctrl !== 2'b00) begin
      n_bad++; $display("FAIL mid_reset_bus: got en=%b bus=%h want en=0 bus=000", lcd_enable, {lcd_ctrl, lcd_data});
    end
    n_cmp++; if (fifo_level !== 3'd0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset_state: got level=%0d busy=%b ready=%b want 0/0/1",
                        fifo_level, busy, cmd_if.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_release: got busy=%b ready=%b want busy=0 ready=1", busy, cmd_if.cmd_ready);
    end
    repeat (20) tick();
    n_cmp++; if (busy !== 1'b0 || cap_q.size() != 0 || lcd_enable !== 1'b0) begin
      n_bad++; $display("FAIL mid_discard: got busy=%b strobes=%0d want busy=0 strobes=0", busy, cap_q.size());
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [8:0] item;
    int sent = 0;
    int n = 0;
    cap_q.delete();
    while (sent < 20 && n < 2000) begin
      if (cmd_if.cmd_ready) begin
        item = 9'($urandom_range(0, 511));
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = item[8];
        cmd_if.cmd_byte  = item[7:0];
        exp_q.push_back(item);
        sent++;
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      tick();
      n++;
    end
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (sent != 20) begin n_bad++; $display("FAIL rand_sent: got %0d want 20", sent); end
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++; if (cap_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rand_item[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_times();
    test_overflow();
    test_push_at_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles RS/data are stable before E rises.
REQ-002 SHALL have parameter PULSE_CYC, default 12: E-high width in cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles RS/data are held after E falls.
REQ-004 SHALL have parameter SHORT_WAIT_CYC, default 2000: execution wait for ordinary commands and data writes.
REQ-005 SHALL have parameter LONG_WAIT_CYC, default 82000: execution wait for clear and home commands.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: command queue entries, a power of two of at least 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port cmd_valid, input, 1 bit: a write request is presented this cycle.
REQ-010 SHALL have port cmd_rs, input, 1 bit: register select, 0 for instruction and 1 for data.
REQ-011 SHALL have port cmd_byte, input, 8 bits: the byte to send to the panel.
REQ-012 SHALL have port cmd_ready, output, 1 bit: the queue is not full.
REQ-013 SHALL have port lcd_data, output, 8 bits: the panel data bus.
REQ-014 SHALL have port lcd_ctrl, output, 2 bits: bit0 is RS and bit1 is RW.
REQ-015 SHALL have port lcd_enable, output, 1 bit: the panel E strobe.
REQ-016 SHALL have port busy, output, 1 bit: the sequencer is not idle or the queue is not empty.
REQ-017 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the number of queued entries.

Function
REQ-018 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1, and SHALL ignore a request when cmd_ready is 0 (no overwrite, no error flag).
REQ-019 SHALL derive cmd_ready combinationally from the level alone, as fifo_level != FIFO_DEPTH; a push while full is rejected even when a pop occurs in the same cycle.
REQ-020 SHALL pop entries in FIFO order and SHALL wrap the pointers modulo FIFO_DEPTH; a simultaneous push and pop on a non-full, non-empty queue leaves fifo_level unchanged.
REQ-021 SHALL implement sequencer states IDLE, SETUP, PULSE, HOLD and WAIT, using one down-counter wide enough for LONG_WAIT_CYC.
REQ-022 SHALL, in IDLE with the queue non-empty, pop one entry, register lcd_data=byte, lcd_ctrl={1'b0,rs}, load the counter and go to SETUP.
REQ-023 SHALL go SETUP→PULSE after SETUP_CYC cycles, with lcd_enable registered 1 for exactly PULSE_CYC cycles.
REQ-024 SHALL go PULSE→HOLD with lcd_enable 0, holding lcd_data and lcd_ctrl stable.
REQ-025 SHALL go HOLD→WAIT after HOLD_CYC cycles.
REQ-026 SHALL go WAIT→IDLE after the wait time, which is LONG_WAIT_CYC if rs==0 and byte[7:2]==0 (clear or home), otherwise SHORT_WAIT_CYC.
REQ-027 SHALL keep lcd_data and lcd_ctrl at their last values in IDLE; lcd_ctrl[1] (RW) is constant 0.
REQ-028 SHALL meet this latency: for a push accepted at edge T into an empty queue with the sequencer idle, data/RS are valid after edge T+1, E rises after edge T+1+SETUP_CYC, and back-to-back commands are spaced SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles apart.
REQ-029 SHALL assert busy while the state is not IDLE or fifo_level != 0.
REQ-030 SHALL treat every registered output as glitch-free; lcd_enable is driven directly from a flop.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-pulse, immediately drive lcd_data=0, lcd_ctrl=0, lcd_enable=0, state=IDLE, counter=0, fifo_level=0, and discard all queued entries.
REQ-032 SHALL have busy=0 and cmd_ready=1 while in reset and on the first cycle after reset is released.

Structure
REQ-033 SHALL place the state enum, the lcd_ctrl bit indices (RS=0, RW=1) and the default timing constants in package lcd_pkg.
REQ-034 SHALL implement the queue as sub-module lcd_cmd_fifo, 9 bits wide ({rs, byte}), FIFO_DEPTH deep, exporting level, full and empty.

Verification (bench parameters SETUP=2, PULSE=3, HOLD=1, SHORT=4, LONG=10, DEPTH=4)
REQ-035 SHALL check a single write: push rs=1, byte=0x41 at edge T gives lcd_data=0x41 and lcd_ctrl=01 from T+1, lcd_enable high during cycles T+3..T+5, and busy low at T+11.
REQ-036 SHALL check the clear command: push rs=0, byte=0x01 gives a command-to-IDLE time of 16 cycles, versus 10 cycles for byte 0x38.
REQ-037 SHALL check overflow: pushing 6 commands back-to-back while idle accepts 5 (one popped, four queued), drops the sixth with cmd_ready=0, and the panel sees exactly 5 bytes in order.
REQ-038 SHALL check push-at-pop: with the queue full, a push in the same cycle as a pop is rejected and fifo_level goes 4→3.
REQ-039 SHALL check reset mid-operation: rst_n asserted while lcd_enable=1 drives lcd_enable, lcd_data and fifo_level to 0 before the next edge, and the controller is idle with cmd_ready=1 after release.
REQ-040 SHALL check data integrity: 20 random {rs, byte} pairs pushed whenever cmd_ready is high match the panel-side capture taken at each lcd_enable falling edge.
